// File: rtl/dma_modport.sv
// dma_modport: register-mapped DMA controller slave.
// Holds the DMA register file and a small transfer engine. The engine counts
// words for a started job, reports busy/done/error and raises a level interrupt.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous reset, active-high despite the name
//   wr_en  - register write strobe
//   rd_en  - register read strobe
//   addr   - byte address, full 32-bit decode
//   wdata  - write data
//   rdata  - registered read data, holds when rd_en is low
//   irq    - level interrupt, combinational from registers
module dma_modport #(
   parameter logic [31:0] BASE_ADDR = 32'h400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 16;
   localparam int unsigned CW = 15;
   localparam int unsigned FW = 9;

   localparam logic [31:0] A_INTR   = BASE_ADDR + 32'h00;
   localparam logic [31:0] A_CTRL   = BASE_ADDR + 32'h04;
   localparam logic [31:0] A_IO     = BASE_ADDR + 32'h08;
   localparam logic [31:0] A_MEM    = BASE_ADDR + 32'h0C;
   localparam logic [31:0] A_EXTRA  = BASE_ADDR + 32'h10;
   localparam logic [31:0] A_STATUS = BASE_ADDR + 32'h14;
   localparam logic [31:0] A_COUNT  = BASE_ADDR + 32'h18;
   localparam logic [31:0] A_DESC   = BASE_ADDR + 32'h1C;
   localparam logic [31:0] A_ERR    = BASE_ADDR + 32'h20;
   localparam logic [31:0] A_CFG    = BASE_ADDR + 32'h24;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUSY  = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_ERROR = 2'd3;

   logic [1:0]    state, state_nxt;
   logic [IW-1:0] intr_status, intr_mask;
   logic [CW-1:0] w_count, job_len, xfer_cnt;
   logic          io_mem;
   logic [DW-1:0] io_addr, mem_addr, extra_info, desc_addr;
   logic          err_status;
   logic [FW-1:0] cfg;
   logic          done_flag, err_flag;

   logic          wr_intr_c, wr_ctrl_c, wr_err_c;
   logic          start_ok_c, set_done_c, set_err_c;
   logic [CW-1:0] cnt_inc_c;
   logic [DW-1:0] rd_mux_c;

   assign wr_intr_c = wr_en && (addr == A_INTR);
   assign wr_ctrl_c = wr_en && (addr == A_CTRL);
   assign wr_err_c  = wr_en && (addr == A_ERR);
   assign cnt_inc_c = xfer_cnt + CW'(1);

   // Engine next state; a start is honoured only from IDLE
   always_comb begin
      state_nxt  = state;
      start_ok_c = 1'b0;
      set_done_c = 1'b0;
      set_err_c  = 1'b0;
      case (state)
         S_IDLE: begin
            if (wr_ctrl_c && wdata[0]) begin
               start_ok_c = 1'b1;
               if (mem_addr[1:0] != 2'b00) begin
                  state_nxt = S_ERROR;
                  set_err_c = 1'b1;
               end else if (wdata[15:1] == CW'(0)) begin
                  state_nxt  = S_DONE;
                  set_done_c = 1'b1;
               end else begin
                  state_nxt = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (cnt_inc_c == job_len) begin
               state_nxt  = S_DONE;
               set_done_c = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERROR: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Read mux of pre-write register values
   always_comb begin
      rd_mux_c = '0;
      case (addr)
         A_INTR:   rd_mux_c = {intr_mask, intr_status};
         A_CTRL:   rd_mux_c = {15'd0, io_mem, w_count, 1'b0};
         A_IO:     rd_mux_c = io_addr;
         A_MEM:    rd_mux_c = mem_addr;
         A_EXTRA:  rd_mux_c = extra_info;
         A_STATUS: rd_mux_c = {29'd0, err_flag, done_flag, (state == S_BUSY)};
         A_COUNT:  rd_mux_c = {17'd0, xfer_cnt};
         A_DESC:   rd_mux_c = desc_addr;
         A_ERR:    rd_mux_c = {31'd0, err_status};
         A_CFG:    rd_mux_c = {23'd0, cfg};
         default:  rd_mux_c = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Register file, engine counters and read data
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         intr_status <= '0;
         intr_mask   <= '0;
         w_count     <= '0;
         io_mem      <= 1'b0;
         io_addr     <= '0;
         mem_addr    <= '0;
         extra_info  <= '0;
         desc_addr   <= '0;
         err_status  <= 1'b0;
         cfg         <= '0;
         job_len     <= '0;
         xfer_cnt    <= '0;
         done_flag   <= 1'b0;
         err_flag    <= 1'b0;
         rdata       <= '0;
      end else begin
         if (wr_intr_c) intr_mask <= wdata[31:16];
         // hardware set takes priority over a same-cycle W1C
         intr_status <= (intr_status & ~(wr_intr_c ? wdata[15:0] : IW'(0)))
                        | {14'd0, set_err_c, set_done_c};
         err_status  <= (err_status & ~(wr_err_c & wdata[0])) | set_err_c;

         if (wr_ctrl_c) begin
            w_count <= wdata[15:1];
            io_mem  <= wdata[16];
         end
         if (wr_en && addr == A_IO)    io_addr    <= wdata;
         if (wr_en && addr == A_MEM)   mem_addr   <= wdata;
         if (wr_en && addr == A_EXTRA) extra_info <= wdata;
         if (wr_en && addr == A_DESC)  desc_addr  <= wdata;
         if (wr_en && addr == A_CFG)   cfg        <= wdata[8:0];

         // running job keeps its own length so later CTRL writes cannot disturb it
         if (start_ok_c) begin
            job_len   <= wdata[15:1];
            xfer_cnt  <= '0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
         end else if (state == S_BUSY) begin
            xfer_cnt <= cnt_inc_c;
         end
         if (set_done_c) done_flag <= 1'b1;
         if (set_err_c)  err_flag  <= 1'b1;

         if (rd_en) rdata <= rd_mux_c;
      end
   end

   assign irq = cfg[3] & (|(intr_status & intr_mask));

endmodule

// File: tb/tb_dma_modport.sv
// tb_dma_modport: self-checking bench for dma_modport.
// Directed scenarios plus a randomized register-bus sequence checked against
// a cycle-count based reference model of the register file and engine.
module tb_dma_modport;

   localparam logic [31:0] B = 32'h400;

   logic        clk;
   logic        rst_n;
   logic        wr_en, rd_en;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   dma_modport #(.BASE_ADDR(B)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [15:0] m_intr, m_mask;
   logic [14:0] m_wcount;
   logic        m_io_mem;
   logic [31:0] m_io, m_mem, m_extra, m_desc;
   logic        m_err;
   logic [8:0]  m_cfg;
   int          cyc;
   bit          job_valid, job_err;
   int          job_s, job_len;
   logic [31:0] exp_rd;

   // a job occupies edges job_s .. job_s+job_len, then the engine is free again
   function automatic bit m_busy();
      return job_valid && !job_err && ((cyc - job_s) < job_len);
   endfunction
   function automatic bit m_idle();
      if (!job_valid) return 1'b1;
      if (job_err) return (cyc - job_s) > 0;
      return (cyc - job_s) > job_len;
   endfunction
   function automatic bit m_done();
      return job_valid && !job_err && ((cyc - job_s) >= job_len);
   endfunction
   function automatic int m_count();
      if (!job_valid || job_err) return 0;
      return ((cyc - job_s) < job_len) ? (cyc - job_s) : job_len;
   endfunction
   function automatic logic m_irq();
      return m_cfg[3] && ((m_intr & m_mask) != 16'h0);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      case (a)
         B + 32'h00: v = {m_mask, m_intr};
         B + 32'h04: v = {15'd0, m_io_mem, m_wcount, 1'b0};
         B + 32'h08: v = m_io;
         B + 32'h0C: v = m_mem;
         B + 32'h10: v = m_extra;
         B + 32'h14: v = {29'd0, (job_valid && job_err), m_done(), m_busy()};
         B + 32'h18: v = 32'(m_count());
         B + 32'h1C: v = m_desc;
         B + 32'h20: v = {31'd0, m_err};
         B + 32'h24: v = {23'd0, m_cfg};
         default:    v = 32'h0;
      endcase
      return v;
   endfunction

   task automatic model_reset();
      m_intr = '0; m_mask = '0; m_wcount = '0; m_io_mem = 1'b0;
      m_io = '0; m_mem = '0; m_extra = '0; m_desc = '0;
      m_err = 1'b0; m_cfg = '0;
      cyc = 0; job_valid = 1'b0; job_err = 1'b0; job_s = 0; job_len = 0;
      exp_rd = '0;
   endtask

   // advance the model by one clock edge carrying an optional write
   task automatic model_step(input bit w, input logic [31:0] a, input logic [31:0] d);
      logic [15:0] clr_i, set_i;
      logic        clr_e, set_e;
      clr_i = '0; set_i = '0; clr_e = 1'b0; set_e = 1'b0;
      if (w) begin
         case (a)
            B + 32'h00: begin clr_i = d[15:0]; m_mask = d[31:16]; end
            B + 32'h04: begin
               if (d[0] && m_idle()) begin
                  job_valid = 1'b1;
                  job_s     = cyc + 1;
                  job_len   = int'(d[15:1]);
                  job_err   = (m_mem[1:0] != 2'b00);
               end
               m_wcount = d[15:1];
               m_io_mem = d[16];
            end
            B + 32'h08: m_io    = d;
            B + 32'h0C: m_mem   = d;
            B + 32'h10: m_extra = d;
            B + 32'h1C: m_desc  = d;
            B + 32'h20: clr_e   = d[0];
            B + 32'h24: m_cfg   = d[8:0];
            default: ;
         endcase
      end
      cyc++;
      if (job_valid && job_err && cyc == job_s) begin set_i[1] = 1'b1; set_e = 1'b1; end
      if (job_valid && !job_err && cyc == job_s + job_len) set_i[0] = 1'b1;
      m_intr = (m_intr & ~clr_i) | set_i;
      m_err  = (m_err & ~clr_e) | set_e;
   endtask

   // one bus cycle; leaves time at posedge+1 with strobes released
   task automatic bus(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] e;
      e = model_read(a);
      wr_en = w; rd_en = r; addr = a; wdata = d;
      @(posedge clk);
      model_step(w, a, d);
      if (r) exp_rd = e;
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      for (int i = 0; i < 10; i++) begin
         bus(1'b0, 1'b1, B + 32'(i * 4), 32'h0);
         checks++;
         if (rdata !== 32'h0) begin errors++; $display("FAIL reset_reg_%0h got %h exp %h", B + 32'(i * 4), rdata, 32'h0); end
      end
      bus(1'b0, 1'b1, 32'h500, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rdata); end
   endtask

   task automatic test_rw();
      bus(1'b1, 1'b0, B + 32'h08, 32'hDEADBEEF);
      bus(1'b1, 1'b0, B + 32'h0C, 32'h00001000);
      bus(1'b1, 1'b0, B + 32'h10, 32'h12345678);
      bus(1'b1, 1'b0, B + 32'h1C, 32'hCAFEF00D);
      bus(1'b0, 1'b1, B + 32'h08, 32'h0);
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_io got %h exp DEADBEEF", rdata); end
      bus(1'b0, 1'b1, B + 32'h0C, 32'h0);
      checks++; if (rdata !== 32'h00001000) begin errors++; $display("FAIL rw_mem got %h exp 00001000", rdata); end
      bus(1'b0, 1'b1, B + 32'h10, 32'h0);
      checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL rw_extra got %h exp 12345678", rdata); end
      bus(1'b0, 1'b1, B + 32'h1C, 32'h0);
      checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_desc got %h exp CAFEF00D", rdata); end
      bus(1'b1, 1'b0, B + 32'h14, 32'hFFFFFFFF);
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL status_ro got %h exp 0", rdata); end
      bus(1'b1, 1'b0, B + 32'h24, 32'hFFFFFFFF);
      bus(1'b0, 1'b1, B + 32'h24, 32'h0);
      checks++; if (rdata !== 32'h000001FF) begin errors++; $display("FAIL cfg_mask got %h exp 000001FF", rdata); end
      bus(1'b1, 1'b0, B + 32'h24, 32'h0);
      bus(1'b1, 1'b0, B + 32'h04, 32'hFFFFFFFE);
      bus(1'b0, 1'b1, B + 32'h04, 32'h0);
      checks++; if (rdata !== 32'h0001FFFE) begin errors++; $display("FAIL ctrl_fields got %h exp 0001FFFE", rdata); end
      bus(1'b1, 1'b0, B + 32'h04, 32'h0);
      bus(1'b1, 1'b1, B + 32'h08, 32'h11111111);
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_same_cycle got %h exp DEADBEEF", rdata); end
      bus(1'b0, 1'b1, B + 32'h08, 32'h0);
      checks++; if (rdata !== 32'h11111111) begin errors++; $display("FAIL rw_after got %h exp 11111111", rdata); end
      idle(2);
      checks++; if (rdata !== 32'h11111111) begin errors++; $display("FAIL rdata_hold got %h exp 11111111", rdata); end
   endtask

   task automatic test_done_irq();
      bus(1'b1, 1'b0, B + 32'h24, 32'h8);
      bus(1'b1, 1'b0, B + 32'h00, 32'h00030000);
      bus(1'b1, 1'b0, B + 32'h04, (32'd5 << 1) | 32'd1);
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL job5_busy got %h exp 1", rdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL job5_irq_busy got %b exp 0", irq); end
      idle(4);
      bus(1'b0, 1'b1, B + 32'h18, 32'h0);
      checks++; if (rdata !== 32'd5) begin errors++; $display("FAIL job5_count got %h exp 5", rdata); end
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL job5_status got %h exp 2", rdata); end
      bus(1'b0, 1'b1, B + 32'h00, 32'h0);
      checks++; if (rdata !== 32'h00030001) begin errors++; $display("FAIL job5_intr got %h exp 00030001", rdata); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL job5_irq got %b exp 1", irq); end
      bus(1'b1, 1'b0, B + 32'h00, 32'h00030001);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL job5_irq_clr got %b exp 0", irq); end
   endtask

   task automatic test_error();
      bus(1'b1, 1'b0, B + 32'h0C, 32'h00001002);
      bus(1'b1, 1'b0, B + 32'h04, (32'd4 << 1) | 32'd1);
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL err_status got %h exp 4", rdata); end
      bus(1'b0, 1'b1, B + 32'h20, 32'h0);
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL err_reg got %h exp 1", rdata); end
      bus(1'b0, 1'b1, B + 32'h00, 32'h0);
      checks++; if (rdata !== 32'h00030002) begin errors++; $display("FAIL err_intr got %h exp 00030002", rdata); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL err_irq got %b exp 1", irq); end
      bus(1'b0, 1'b1, B + 32'h18, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL err_count got %h exp 0", rdata); end
      bus(1'b1, 1'b0, B + 32'h20, 32'h1);
      bus(1'b0, 1'b1, B + 32'h20, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL err_w1c got %h exp 0", rdata); end
      bus(1'b1, 1'b0, B + 32'h00, 32'h00030002);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL err_irq_clr got %b exp 0", irq); end
   endtask

   task automatic test_back_to_back();
      bus(1'b1, 1'b0, B + 32'h0C, 32'h00001000);
      bus(1'b1, 1'b0, B + 32'h04, 32'h1);
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL zero_status got %h exp 2", rdata); end
      bus(1'b0, 1'b1, B + 32'h18, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL zero_count got %h exp 0", rdata); end
      bus(1'b1, 1'b0, B + 32'h04, (32'd10 << 1) | 32'd1);
      idle(2);
      bus(1'b1, 1'b0, B + 32'h04, (32'd3 << 1) | 32'd1);
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL restart_busy got %h exp 1", rdata); end
      bus(1'b0, 1'b1, B + 32'h18, 32'h0);
      checks++; if (rdata !== 32'd4) begin errors++; $display("FAIL restart_mid got %h exp 4", rdata); end
      idle(5);
      bus(1'b0, 1'b1, B + 32'h18, 32'h0);
      checks++; if (rdata !== 32'd10) begin errors++; $display("FAIL restart_count got %h exp 10", rdata); end
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL restart_status got %h exp 2", rdata); end
      bus(1'b0, 1'b1, B + 32'h04, 32'h0);
      checks++; if (rdata !== 32'h6) begin errors++; $display("FAIL restart_ctrl got %h exp 6", rdata); end
   endtask

   task automatic test_reset_mid();
      bus(1'b1, 1'b0, B + 32'h04, (32'd100 << 1) | 32'd1);
      idle(19);
      bus(1'b0, 1'b1, B + 32'h18, 32'h0);
      checks++; if (rdata !== 32'd19) begin errors++; $display("FAIL mid_count got %h exp 19", rdata); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre got %b exp 1", irq); end
      #2 rst_n = 1'b1;
      #1;
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata got %h exp 0", rdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      bus(1'b0, 1'b1, B + 32'h18, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_count_post got %h exp 0", rdata); end
      bus(1'b0, 1'b1, B + 32'h14, 32'h0);
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_status_post got %h exp 0", rdata); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         int unsigned idx;
         logic [31:0] a, d;
         bit          w, r;
         idx = $urandom_range(0, 13);
         case (idx)
            10: a = 32'h428;
            11: a = 32'h3FC;
            12: a = 32'h402;
            13: a = 32'h500;
            default: a = B + 32'(idx * 4);
         endcase
         d = $urandom;
         if (a == B + 32'h04) d[15:1] = 15'($urandom_range(0, 6));
         if (a == B + 32'h0C && $urandom_range(0, 2) != 0) d[1:0] = 2'b00;
         w = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 1) == 1);
         bus(w, r, a, d);
         checks++;
         if (rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata n=%0d addr=%h got %h exp %h", n, a, rdata, exp_rd); end
         checks++;
         if (irq !== m_irq()) begin errors++; $display("FAIL rand_irq n=%0d got %b exp %b", n, irq, m_irq()); end
      end
   endtask

   initial begin
      rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
      model_reset();
      test_reset();
      test_rw();
      test_done_irq();
      test_error();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_modport.md
Name: dma_modport

Overview:
- Register-mapped DMA controller slave on a simple single-cycle register bus (wr_en, rd_en, addr, wdata, rdata).
- Holds the programmable DMA register file and a minimal transfer engine that counts words, reports status and raises an interrupt.
- Sits behind the register-bus driver and monitor; it is the target of the register model.

Parameters:
- BASE_ADDR, 32'h400, byte address of the first register; registers are spaced 4 bytes apart.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1) despite the name.
- wr_en  input  1  write strobe, sampled at posedge clk.
- rd_en  input  1  read strobe, sampled at posedge clk.
- addr  input  32  byte address, full 32-bit decode.
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- irq  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On reset, all registers, rdata, irq and the engine go to 0/IDLE immediately. Reset mid-transfer aborts the transfer; count and status clear.
- Register map (offset from BASE_ADDR):
  - 0x00 INTR: [15:0] intr_status, write-1-to-clear; [31:16] intr_mask, read/write.
  - 0x04 CTRL: [0] start_dma, write-only pulse, reads 0; [15:1] w_count, read/write; [16] io_mem, read/write; [31:17] reads 0.
  - 0x08 IO_ADDR: read/write, 32 bits.
  - 0x0C MEM_ADDR: read/write, 32 bits.
  - 0x10 EXTRA_INFO: read/write, 32 bits.
  - 0x14 STATUS: read-only. [0] busy; [1] done; [2] error; [31:3] 0.
  - 0x18 TRANSFER_COUNT: read-only; [14:0] words transferred; upper bits 0.
  - 0x1C DESCRIPTOR_ADDR: read/write, 32 bits.
  - 0x20 ERROR_STATUS: [0] alignment_error, write-1-to-clear; [31:1] 0.
  - 0x24 CONFIG: [3] interrupt_enable, read/write; other bits read/write storage, bits [8:0] only; [31:9] 0.
- All register reset values are 0.
- Writes:
  - Take effect at the posedge where wr_en=1.
  - Writes to read-only fields and to unmapped addresses are ignored.
- Reads:
  - rd_en=1 at edge N updates rdata at edge N.
  - rdata is valid from edge N to edge N+1.
  - rdata holds its value when rd_en=0.
  - Unmapped address reads return 0.
  - Simultaneous wr_en and rd_en to the same address: the read returns the pre-write value; the write still happens.
- Engine states and transitions:
  - IDLE -> on a write of CTRL with wdata[0]=1:
    - if MEM_ADDR[1:0]!=0 -> ERROR;
    - else if new w_count==0 -> DONE;
    - else -> BUSY.
    - TRANSFER_COUNT clears to 0 on start; done and error clear.
  - BUSY: busy=1; TRANSFER_COUNT increments by 1 per clock. When TRANSFER_COUNT reaches w_count, go to DONE. An n-word job completes n cycles after the start write.
  - DONE: busy=0, done=1, intr_status[0] set; return to IDLE next cycle. The done flag stays sticky until the next start.
  - ERROR: error=1, ERROR_STATUS[0]=1, intr_status[1] set; return to IDLE. The error flag stays sticky until the next start.
  - A start while BUSY is ignored. Other CTRL fields written while BUSY are stored but do not affect the running job, which latches w_count at start.
- W1C vs hardware set: a hardware set wins over a software clear in the same cycle.
- Interrupt: irq = CONFIG[3] & |(intr_status & intr_mask), computed combinationally from registers.

Test Plan:
- Reset then read every address 0x400..0x424 -> all 0. Read 0x500 -> 0.
- Write 0x408=0xDEADBEEF, 0x40C=0x1000, 0x410=0x12345678, 0x41C=0xCAFEF00D; read back -> same values. Write 0x414=0xFFFFFFFF -> STATUS still 0.
- CONFIG=0x8, INTR mask=0x0003_0000 (write 0x00030000 to 0x400), CTRL=(5<<1)|1 -> busy=1; after 5 cycles TRANSFER_COUNT=5, STATUS=0x2, intr_status=0x1, irq=1. Write 0x1 to 0x400 -> irq=0.
- MEM_ADDR=0x1002, CTRL start with w_count=4 -> STATUS=0x4, ERROR_STATUS=0x1, intr_status bit1 set, TRANSFER_COUNT=0. W1C 0x420 -> 0.
- CTRL start with w_count=0 -> STATUS=0x2 next cycle, count 0. Start w_count=10, restart at cycle 3 -> ignored, count reaches 10.
- Start w_count=100, assert rst_n=1 at cycle 20 -> count 0, STATUS 0, irq 0 immediately.
